seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_abs.sv | 21 ++
 rtl/seq_multiplier.sv | 121 ++++++++++++
 tb/tb_seq_multiplier.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential multiplier.
package mul_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_abs.sv
// Conditional magnitude: negates a two's-complement value when signed_mode
// is set and the value is negative; passes raw bits through otherwise.
// The most negative value maps onto itself, which read as unsigned is the
// correct magnitude 2^(W-1).
module mul_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         signed_mode,
    output logic [W-1:0] mag
);

    // Select raw value or its two's-complement negation.
    always_comb begin
        mag = val;
        if (signed_mode && val[W-1]) begin
            mag = -val;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: one multiplier bit per cycle on magnitudes,
// sign applied once at the end. Optional early exit once the remaining
// multiplier bits are all zero.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     a_mag, b_mag;

    mul_abs #(.W(WIDTH)) u_abs_a (
        .val         (a),
        .signed_mode (signed_mode),
        .mag         (a_mag)
    );

    mul_abs #(.W(WIDTH)) u_abs_b (
        .val         (b),
        .signed_mode (signed_mode),
        .mag         (b_mag)
    );

    // Next-state and datapath: load on start, shift/add in CALC, sign-fix in FIX.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                // A zero multiplier on entry (b == 0) exits without work.
                if (EARLY_EXIT != 0 && mplier_q == '0) begin
                    state_d = FIX;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mplier_d = mplier_q >> 1;
                    mcand_d  = mcand_q << 1;
                    cnt_d    = cnt_q - CW'(1);
                    // Leave right after the last set bit is consumed.
                    if (cnt_q == CW'(1) || (EARLY_EXIT != 0 && mplier_d == '0)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                result_d = neg_q ? -acc_q : acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: two instances (early exit on/off) driven in parallel,
// a latency/product model checked every cycle, plus literal directed cases.
module tb_seq_multiplier;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sm = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy1, done1, busy0, done0;
    logic [2*W-1:0] res1, res0;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy1), .done(done1), .result(res1)
    );

    seq_multiplier #(.WIDTH(W), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy0), .done(done0), .result(res0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product from plain wide arithmetic.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input bit s);
        logic [63:0] wx, wy;
        wx = s ? {{32{x[31]}}, x} : {32'b0, x};
        wy = s ? {{32{y[31]}}, y} : {32'b0, y};
        return wx * wy;
    endfunction

    // Number of CALC cycles the operation is allowed to take.
    function automatic int ref_n(input logic [31:0] y, input bit s, input bit ee);
        logic [31:0] m;
        int n;
        if (!ee) return 32;
        m = (s && y[31]) ? -y : y;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return (n < 1) ? 1 : n;
    endfunction

    // Model: index 1 = early exit, index 0 = full count.
    int          rem [2] = '{0, 0};
    logic [63:0] pend[2] = '{64'd0, 64'd0};
    logic [63:0] mres[2] = '{64'd0, 64'd0};
    bit          mdone[2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                rem[k]   <= 0;
                mres[k]  <= '0;
                mdone[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mdone[k] <= 1'b0;
                if (rem[k] > 0) begin
                    rem[k] <= rem[k] - 1;
                    if (rem[k] == 1) begin
                        mres[k]  <= pend[k];
                        mdone[k] <= 1'b1;
                    end
                end else if (start) begin
                    pend[k] <= ref_prod(a, b, sm);
                    rem[k]  <= ref_n(b, sm, k == 1) + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_ee", {63'b0, busy1}, {63'b0, rem[1] > 0});
            chk("done_ee", {63'b0, done1}, {63'b0, mdone[1]});
            chk("result_ee", res1, mres[1]);
            chk("busy_ne", {63'b0, busy0}, {63'b0, rem[0] > 0});
            chk("done_ne", {63'b0, done0}, {63'b0, mdone[0]});
            chk("result_ne", res0, mres[0]);
        end
    end

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit s,
                         input logic [63:0] er, input int l1, input int l0);
        int e1, e0;
        e1 = -1;
        e0 = -1;
        @(posedge clk); #1;
        start = 1'b1; a = x; b = y; sm = s;
        @(posedge clk); #1;   // edge 0 has sampled start
        start = 1'b0;
        for (int e = 1; e <= 40 && (e1 < 0 || e0 < 0); e++) begin
            @(posedge clk); #1;
            if (done1 && e1 < 0) e1 = e;
            if (done0 && e0 < 0) e0 = e;
        end
        chk("lat_ee", 64'(e1), 64'(l1));
        chk("lat_ne", 64'(e0), 64'(l0));
        chk("lit_ee", res1, er);
        chk("lit_ne", res0, er);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_bound", {63'b0, n < 200}, 64'd1);
    endtask

    task automatic wait_done1();
        int n;
        n = 0;
        while (!done1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_bound", {63'b0, n < 60}, 64'd1);
    endtask

    initial begin
        #1;
        chk_en = 1'b1;
        #1;
        chk("rst_busy", {62'b0, busy1, busy0}, 64'd0);
        chk("rst_done", {62'b0, done1, done0}, 64'd0);
        chk("rst_res", res1 | res0, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(32'h0000000F, 32'h00000003, 1'b0, 64'h2D, 3, 33);
        do_op(32'h11111111, 32'h00000000, 1'b0, 64'h0, 2, 33);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 33, 33);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 2, 33);
        do_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 33, 33);
        do_op(32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1, 4, 33);

        // Restart attempt mid-CALC, then back-to-back start on the done cycle.
        @(posedge clk); #1;
        start = 1'b1; a = 32'h1234; b = 32'h00FF; sm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 32'd99; b = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done1();
        chk("restart_ignored", res1, 64'h1221CC);
        start = 1'b1; a = 32'h00010001; b = 32'h0000FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accepted", {63'b0, busy1}, 64'd1);
        wait_done1();
        chk("b2b_result", res1, 64'h00000000FFFFFFFF);
        wait_idle();
        chk("ne_first_result", res0, 64'h1221CC);

        // Reset pulse during CALC.
        @(posedge clk); #1;
        start = 1'b1; a = 32'd5; b = 32'h0000FFFF; sm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {62'b0, busy1, busy0}, 64'd0);
        chk("rst_mid_res", res1 | res0, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(32'h00000007, 32'h00000006, 1'b0, 64'h2A, 4, 33);

        // Randomized operations with stray start pulses while busy.
        repeat (25) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'h0;
                1: y = y & 32'hFF;
                2: y = ($urandom_range(0, 1) != 0) ? 32'h80000000 : (y & 32'hFFFF);
                default: ;
            endcase
            @(posedge clk); #1;
            start = 1'b1; a = x; b = y; sm = ($urandom_range(0, 1) != 0);
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                start = ($urandom_range(0, 3) == 0);
                a = $urandom;
                b = $urandom;
                sm = ($urandom_range(0, 1) != 0);
            end
            start = 1'b0;
            wait_idle();
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
